axi_checker_chip: RTL and testbench

Self-contained simulation top for the AXI4-Stream checker test. It wraps an `ex_design` hierarchy in which an AXI4-Stream master VIP feeds a checker core, and the checker core drives an AXI4-Stream slave VIP. The checker core is a registered pass-through. It forwards 512-bit stream beats unchanged and keeps beat, packet and protocol-error counters that benches read hierarchically. The only external pins are clock and reset; all stimulus and response pass through the VIP agents.

---
 rtl/axi_checker_chip_if.sv | 12 +
 rtl/axi_checker_chip.sv | 146 ++++++++++++++
 tb/tb_axi_checker_chip.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_checker_chip_if.sv
// AXI4-Stream link (tvalid/tready/tdata/tlast) shared by the VIP agents and the checker core.
interface axi_checker_chip_if #(
  parameter int TDATA_W = 512
) ();
  logic               tvalid;
  logic               tready;
  logic [TDATA_W-1:0] tdata;
  logic               tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_checker_chip.sv
// AXI4-Stream checker chip: master VIP -> checker core (2-entry skid buffer + counters) -> slave VIP.
// aresetn is active-high and asynchronous despite its name.
module axi_checker_chip #(
  parameter int TDATA_W = 512,
  parameter int CNT_W   = 32
) (
  input  logic               aclk,
  input  logic               aresetn,
  axi_checker_chip_if.slave  mst_agent_i,
  axi_checker_chip_if.master slv_agent_o
);
  axi_checker_ex_design #(.TDATA_W(TDATA_W), .CNT_W(CNT_W)) ex_design (
    .clk       (aclk),
    .rst       (aresetn),
    .mst_agent (mst_agent_i),
    .slv_agent (slv_agent_o)
  );
endmodule

module axi_checker_ex_design #(
  parameter int TDATA_W = 512,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  axi_checker_chip_if.slave  mst_agent,
  axi_checker_chip_if.master slv_agent
);
  axi_checker_chip_if #(.TDATA_W(TDATA_W)) s_link ();
  axi_checker_chip_if #(.TDATA_W(TDATA_W)) m_link ();

  axi_checker_vip axi4stream_vip_mst (.up(mst_agent), .dn(s_link));
  axi_checker_vip axi4stream_vip_slv (.up(m_link),    .dn(slv_agent));

  // 'checker' is a reserved word, so the core instance is named chk.
  axi_checker_core #(.TDATA_W(TDATA_W), .CNT_W(CNT_W)) chk (
    .clk (clk),
    .rst (rst),
    .s   (s_link),
    .m   (m_link)
  );
endmodule

module axi_checker_vip (
  axi_checker_chip_if.slave  up,
  axi_checker_chip_if.master dn
);
  assign dn.tvalid = up.tvalid;
  assign dn.tdata  = up.tdata;
  assign dn.tlast  = up.tlast;
  assign up.tready = dn.tready;
endmodule

module axi_checker_core #(
  parameter int TDATA_W = 512,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  axi_checker_chip_if.slave  s,
  axi_checker_chip_if.master m
);
  logic               main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, s_rdy_q;
  logic [TDATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d, prev_data_q;
  logic               main_last_q, main_last_d, skid_last_q, skid_last_d, prev_last_q;
  logic               stall_q, up_hs, dn_hs, proto_err;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]   out_beat_cnt_q, out_beat_cnt_d, err_cnt_q, err_cnt_d;
  logic               err_flag_q, err_flag_d;

  always_comb begin
    up_hs       = s.tvalid & s_rdy_q;
    dn_hs       = main_vld_q & m.tready;
    main_vld_d  = main_vld_q;
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    // Main register refills from skid first so beat order is kept.
    if (!main_vld_q || dn_hs) begin
      if (skid_vld_q) begin
        main_vld_d  = 1'b1;
        main_data_d = skid_data_q;
        main_last_d = skid_last_q;
        skid_vld_d  = 1'b0;
      end else begin
        main_vld_d  = up_hs;
        main_data_d = s.tdata;
        main_last_d = s.tlast;
      end
    end else if (up_hs) begin
      skid_vld_d  = 1'b1;
      skid_data_d = s.tdata;
      skid_last_d = s.tlast;
    end

    proto_err = stall_q & (~s.tvalid | (s.tdata != prev_data_q) | (s.tlast != prev_last_q));

    beat_cnt_d     = beat_cnt_q + CNT_W'(up_hs);
    pkt_cnt_d      = pkt_cnt_q + CNT_W'(up_hs & s.tlast);
    out_beat_cnt_d = out_beat_cnt_q + CNT_W'(dn_hs);
    err_cnt_d      = err_cnt_q + CNT_W'(proto_err);
    err_flag_d     = err_flag_q | proto_err;
  end

  // Control state stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_q     <= 1'b0;
      skid_vld_q     <= 1'b0;
      s_rdy_q        <= 1'b0;
      stall_q        <= 1'b0;
      beat_cnt_q     <= '0;
      pkt_cnt_q      <= '0;
      out_beat_cnt_q <= '0;
      err_cnt_q      <= '0;
      err_flag_q     <= 1'b0;
    end else begin
      main_vld_q     <= main_vld_d;
      skid_vld_q     <= skid_vld_d;
      s_rdy_q        <= ~skid_vld_d;
      stall_q        <= s.tvalid & ~s_rdy_q;
      beat_cnt_q     <= beat_cnt_d;
      pkt_cnt_q      <= pkt_cnt_d;
      out_beat_cnt_q <= out_beat_cnt_d;
      err_cnt_q      <= err_cnt_d;
      err_flag_q     <= err_flag_d;
    end
  end

  // Data stage: payload registers carry no reset, validity lives in the control bits
  always_ff @(posedge clk) begin
    main_data_q <= main_data_d;
    main_last_q <= main_last_d;
    skid_data_q <= skid_data_d;
    skid_last_q <= skid_last_d;
    prev_data_q <= s.tdata;
    prev_last_q <= s.tlast;
  end

  assign m.tvalid = main_vld_q;
  assign m.tdata  = main_data_q;
  assign m.tlast  = main_last_q;
  assign s.tready = s_rdy_q;
endmodule

// File: tb/tb_axi_checker_chip.sv
// Bench for axi_checker_chip: directed packets, randomized traffic and backpressure against a queue model.
`timescale 1ns/1ps
module tb_axi_checker_chip;
  localparam int W = 512;
  typedef logic [W:0] word_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  axi_checker_chip_if #(.TDATA_W(W)) mst_if ();
  axi_checker_chip_if #(.TDATA_W(W)) slv_if ();

  axi_checker_chip #(.TDATA_W(W), .CNT_W(32)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .mst_agent_i (mst_if),
    .slv_agent_o (slv_if)
  );

  int    total = 0, bad = 0;
  word_t exp_q[$];
  word_t rx_q[$];
  int    ready_mode = 0;
  int    low_run = 0, max_low = 0, hold_viol = 0;
  logic  stall_seen = 1'b0;
  word_t stall_beat = '0;

  task automatic chk(input string tag, input word_t got, input word_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave-side ready pattern
  initial begin
    int ph = 0;
    slv_if.tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      ph = (ph + 1) % 8;
      case (ready_mode)
        0:       slv_if.tready = 1'b1;
        1:       slv_if.tready = (ph >= 2);
        2:       slv_if.tready = ($urandom_range(0, 3) != 0);
        default: slv_if.tready = 1'b0;
      endcase
    end
  end

  // Downstream monitor and upstream ready tracker
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        low_run = 0;
        stall_seen = 1'b0;
      end else begin
        if (slv_if.tvalid && slv_if.tready) rx_q.push_back({slv_if.tlast, slv_if.tdata});
        if (stall_seen && (!slv_if.tvalid || {slv_if.tlast, slv_if.tdata} != stall_beat)) hold_viol++;
        stall_seen = slv_if.tvalid && !slv_if.tready;
        stall_beat = {slv_if.tlast, slv_if.tdata};
        if (!mst_if.tready) begin
          low_run++;
          if (low_run > max_low) max_low = low_run;
        end else begin
          low_run = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [W-1:0] d, input logic l);
    int n = 0;
    mst_if.tvalid = 1'b1;
    mst_if.tdata  = d;
    mst_if.tlast  = l;
    do begin
      @(negedge aclk);
      n++;
    end while (!mst_if.tready && n < 200);
    if (!mst_if.tready) chk("put_ready_timeout", word_t'(mst_if.tready), word_t'(1));
    @(posedge aclk); #1;
    mst_if.tvalid = 1'b0;
    mst_if.tlast  = 1'b0;
    exp_q.push_back({l, d});
  endtask

  task automatic reset_dut(input int cyc, input bit check);
    aresetn = 1'b1;
    mst_if.tvalid = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge aclk);
      if (check) begin
        chk($sformatf("rst_m_tvalid_%0d", i), word_t'(slv_if.tvalid), word_t'(0));
        chk($sformatf("rst_s_tready_%0d", i), word_t'(mst_if.tready), word_t'(0));
        chk($sformatf("rst_beat_cnt_%0d", i), word_t'(dut.ex_design.chk.beat_cnt_q), word_t'(0));
        chk($sformatf("rst_pkt_cnt_%0d", i), word_t'(dut.ex_design.chk.pkt_cnt_q), word_t'(0));
        chk($sformatf("rst_out_cnt_%0d", i), word_t'(dut.ex_design.chk.out_beat_cnt_q), word_t'(0));
        chk($sformatf("rst_err_cnt_%0d", i), word_t'(dut.ex_design.chk.err_cnt_q), word_t'(0));
        chk($sformatf("rst_err_flag_%0d", i), word_t'(dut.ex_design.chk.err_flag_q), word_t'(0));
      end
    end
    @(posedge aclk); #1;
    aresetn = 1'b0;
    exp_q.delete();
    rx_q.delete();
    max_low = 0;
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 400 && rx_q.size() < n; i++) @(negedge aclk);
    repeat (3) @(negedge aclk);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, word_t'(rx_q.size()), word_t'(exp_q.size()));
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), rx_q[i], exp_q[i]);
  endtask

  task automatic chk_counts(input string tag, input int beats, input int pkts, input int errs);
    chk({tag, "_beat_cnt"}, word_t'(dut.ex_design.chk.beat_cnt_q), word_t'(beats));
    chk({tag, "_out_cnt"}, word_t'(dut.ex_design.chk.out_beat_cnt_q), word_t'(beats));
    chk({tag, "_pkt_cnt"}, word_t'(dut.ex_design.chk.pkt_cnt_q), word_t'(pkts));
    chk({tag, "_err_cnt"}, word_t'(dut.ex_design.chk.err_cnt_q), word_t'(errs));
  endtask

  task automatic send_t1();
    logic [W-1:0] d;
    for (int k = 0; k < 8; k++) begin
      d = '0;
      d[7:0] = 8'(k * 15);
      put(d, k == 7);
    end
  endtask

  initial begin
    logic [W-1:0] d;
    int pkts;
    mst_if.tvalid = 1'b0;
    mst_if.tdata  = '0;
    mst_if.tlast  = 1'b0;

    // T3: reset holds everything idle, ready rises one cycle after release
    #1;
    reset_dut(5, 1'b1);
    @(posedge aclk);
    @(negedge aclk);
    chk("t3_s_tready_after_release", word_t'(mst_if.tready), word_t'(1));

    // T1: basic packet, slave always ready
    @(posedge aclk); #1;
    ready_mode = 0;
    send_t1();
    wait_rx(8);
    cmp_stream("t1");
    chk_counts("t1", 8, 1, 0);

    // T2: oscillating downstream ready
    ready_mode = 1;
    reset_dut(2, 1'b0);
    send_t1();
    ready_mode = 0;
    wait_rx(8);
    cmp_stream("t2");
    chk_counts("t2", 8, 1, 0);
    chk("t2_s_tready_low_le3", word_t'(max_low <= 3), word_t'(1));

    // T5: reset in the middle of a packet, then rerun the packet
    reset_dut(2, 1'b0);
    for (int k = 0; k < 3; k++) begin
      d = '0;
      d[7:0] = 8'(k * 15);
      put(d, 1'b0);
    end
    reset_dut(2, 1'b0);
    send_t1();
    wait_rx(8);
    cmp_stream("t5");
    chk_counts("t5", 8, 1, 0);

    // Randomized packets with random downstream ready and upstream gaps
    ready_mode = 2;
    reset_dut(2, 1'b0);
    for (int p = 0; p < 15; p++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        for (int j = 0; j < W / 32; j++) d[j*32 +: 32] = $urandom();
        put(d, b == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge aclk); #1;
        end
      end
    end
    ready_mode = 0;
    wait_rx(exp_q.size());
    cmp_stream("rnd");
    pkts = 0;
    foreach (exp_q[i]) if (exp_q[i][W]) pkts++;
    chk_counts("rnd", exp_q.size(), pkts, 0);

    // T4: master drops tvalid while stalled
    ready_mode = 3;
    reset_dut(2, 1'b0);
    @(posedge aclk); #1;
    put({W{1'b0}} | 512'hA1, 1'b0);
    put({W{1'b0}} | 512'hB2, 1'b0);
    mst_if.tvalid = 1'b1;
    mst_if.tdata  = 512'hC3;
    mst_if.tlast  = 1'b0;
    @(negedge aclk);
    chk("t4_s_tready_stalled", word_t'(mst_if.tready), word_t'(0));
    @(posedge aclk); #1;
    mst_if.tvalid = 1'b0;
    repeat (2) @(negedge aclk);
    chk("t4_err_cnt", word_t'(dut.ex_design.chk.err_cnt_q), word_t'(1));
    chk("t4_err_flag", word_t'(dut.ex_design.chk.err_flag_q), word_t'(1));
    chk("t4_beat_cnt_stalled", word_t'(dut.ex_design.chk.beat_cnt_q), word_t'(2));
    ready_mode = 0;
    @(posedge aclk); #1;
    put({W{1'b0}} | 512'hD4, 1'b1);
    wait_rx(3);
    cmp_stream("t4");
    chk_counts("t4", 3, 1, 1);
    chk("t4_err_flag_sticky", word_t'(dut.ex_design.chk.err_flag_q), word_t'(1));

    // T6: beat counter wraps
    @(posedge aclk); #1;
    force dut.ex_design.chk.beat_cnt_q = 32'hFFFF_FFFF;
    @(posedge aclk); #1;
    release dut.ex_design.chk.beat_cnt_q;
    @(negedge aclk);
    chk("t6_beat_cnt_max", word_t'(dut.ex_design.chk.beat_cnt_q), word_t'(32'hFFFF_FFFF));
    @(posedge aclk); #1;
    put({W{1'b0}} | 512'hE5, 1'b1);
    @(negedge aclk);
    chk("t6_beat_cnt_wrap", word_t'(dut.ex_design.chk.beat_cnt_q), word_t'(0));
    chk("t6_pkt_cnt", word_t'(dut.ex_design.chk.pkt_cnt_q), word_t'(2));

    chk("downstream_hold_violations", word_t'(hold_viol), word_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
